// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the multi-channel counter.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Ceiling log2, for sizing index fields from a count.
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned bits;
        longint unsigned v;
        bits = 0;
        v    = (value > 64'd0) ? value - 64'd1 : 64'd0;
        while (v > 64'd0) begin
            v    = v >> 1;
            bits = bits + 1;
        end
        return bits;
    endfunction

    // Saturation cannot coexist with cascading: a held channel never carries.
    function automatic bit mode_ok(input int unsigned cascade, input int unsigned saturate);
        return !((cascade != 0) && (saturate != 0));
    endfunction

    // Terminal value must be reachable and fit in the channel width.
    function automatic bit max_count_ok(input int unsigned width, input longint unsigned max_count);
        return (max_count >= 64'd1) && (max_count <= ((64'd1 << width) - 64'd1));
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: value, terminal-count pulse, sticky overflow and carry.
module counter_channel
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SATURATE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             carry_c
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] clamp;
    logic             at_bound;
    logic             tc_nxt;
    logic             ovf_nxt;

    // Boundary detect, carry out (suppressed by a load) and next-value arithmetic.
    always_comb begin
        at_bound = up_dn ? (q == MAXV) : (q == ZERO);
        carry_c  = adv & at_bound & ~load;
        clamp    = (load_val > MAXV) ? MAXV : load_val;
        if (up_dn) begin
            if (q == MAXV) step = (SATURATE == CNT_SAT) ? MAXV : ZERO;
            else           step = q + ONE;
        end else begin
            if (q == ZERO) step = (SATURATE == CNT_SAT) ? ZERO : MAXV;
            else           step = q - ONE;
        end
    end

    // Next-state selection: load beats count beats hold; a terminal event beats ovf_clr.
    always_comb begin
        q_nxt   = q;
        tc_nxt  = carry_c;
        ovf_nxt = carry_c | (ovf & ~ovf_clr);
        if (load) begin
            q_nxt = clamp;
        end else if (adv) begin
            q_nxt = step;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            tc  <= tc_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: rtl/counter_multichannel.sv
// N independent counters with optional cascading into one wide counter.
module counter_multichannel
    import counter_pkg::*;
#(
    parameter int unsigned     NUM_CH    = 2,
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SATURATE  = CNT_WRAP,
    parameter int unsigned     CASCADE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up_dn,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH-1:0]       ovf_clr,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf
);

    if (!mode_ok(CASCADE, SATURATE)) begin : g_bad_mode
        $error("counter_multichannel: SATURATE must be 0 when CASCADE is 1");
    end
    if (!max_count_ok(WIDTH, MAX_COUNT)) begin : g_bad_max
        $error("counter_multichannel: MAX_COUNT out of range for WIDTH");
    end

    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] carry;
    logic              carry_unused;

    // The last channel's carry (and all carries when not cascading) has no consumer.
    assign carry_unused = ^carry;

    // One channel per slice; in cascade mode each channel is gated by the previous carry.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (i == 0 || CASCADE == 0) begin : g_solo
            assign adv[i] = en[i];
        end else begin : g_chain
            assign adv[i] = en[i] & carry[i-1];
        end

        counter_channel #(
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT),
            .SATURATE  (SATURATE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv[i]),
            .up_dn    (up_dn[i]),
            .load     (load[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .ovf_clr  (ovf_clr[i]),
            .q        (q[i*WIDTH +: WIDTH]),
            .tc       (tc[i]),
            .ovf      (ovf[i]),
            .carry_c  (carry[i])
        );
    end

endmodule

// File: tb/tb_counter_multichannel.sv
// Directed bench for counter_multichannel across wrap, modulus, saturate and cascade builds.
module tb_counter_multichannel;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default build: 2 x 8-bit wrap.
    logic [1:0]  a_en, a_up, a_load, a_clr, a_tc, a_ovf;
    logic [15:0] a_lv, a_q;
    // Modulus-10 single channel.
    logic [0:0]  m_en, m_up, m_load, m_clr, m_tc, m_ovf;
    logic [3:0]  m_lv, m_q;
    // Saturating modulus-6 single channel.
    logic [0:0]  s_en, s_up, s_load, s_clr, s_tc, s_ovf;
    logic [3:0]  s_lv, s_q;
    // Cascaded 3 x 4-bit.
    logic [2:0]  c_en, c_up, c_load, c_clr, c_tc, c_ovf;
    logic [11:0] c_lv, c_q;

    counter_multichannel u_wrap (
        .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .ovf_clr(a_clr), .q(a_q), .tc(a_tc), .ovf(a_ovf)
    );

    counter_multichannel #(.NUM_CH(1), .WIDTH(4), .MAX_COUNT(9)) u_mod (
        .clk(clk), .rst(rst), .en(m_en), .up_dn(m_up), .load(m_load),
        .load_val(m_lv), .ovf_clr(m_clr), .q(m_q), .tc(m_tc), .ovf(m_ovf)
    );

    counter_multichannel #(.NUM_CH(1), .WIDTH(4), .MAX_COUNT(5), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .load(s_load),
        .load_val(s_lv), .ovf_clr(s_clr), .q(s_q), .tc(s_tc), .ovf(s_ovf)
    );

    counter_multichannel #(.NUM_CH(3), .WIDTH(4), .CASCADE(1)) u_cas (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(c_up), .load(c_load),
        .load_val(c_lv), .ovf_clr(c_clr), .q(c_q), .tc(c_tc), .ovf(c_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        a_en = '0; a_up = '0; a_load = '0; a_clr = '0; a_lv = '0;
        m_en = '0; m_up = '0; m_load = '0; m_clr = '0; m_lv = '0;
        s_en = '0; s_up = '0; s_load = '0; s_clr = '0; s_lv = '0;
        c_en = '0; c_up = '0; c_load = '0; c_clr = '0; c_lv = '0;
        tick();
        check("rst_q",   64'(a_q),   64'h0);
        check("rst_tc",  64'(a_tc),  64'h0);
        check("rst_ovf", 64'(a_ovf), 64'h0);

        // Default wrap: 256 up-counts return to 0 with one tc pulse per channel.
        rst = 1'b0; a_en = 2'b11; a_up = 2'b11;
        repeat (255) tick();
        check("wrap_q255",  64'(a_q),   64'hFFFF);
        check("wrap_tc_pre", 64'(a_tc), 64'h0);
        tick();
        check("wrap_q0",  64'(a_q),   64'h0000);
        check("wrap_tc",  64'(a_tc),  64'h3);
        check("wrap_ovf", 64'(a_ovf), 64'h3);
        tick();
        check("wrap_q1",    64'(a_q),  64'h0101);
        check("wrap_tc_end", 64'(a_tc), 64'h0);
        rst = 1'b1;
        tick();
        check("rst_mid_q",   64'(a_q),   64'h0);
        check("rst_mid_ovf", 64'(a_ovf), 64'h0);
        rst = 1'b0;

        // Priority: load beats count; reset beats load.
        a_load = 2'b01; a_lv = 16'h002A;
        tick();
        check("prio_load_q",  64'(a_q),  64'h012A);
        check("prio_load_tc", 64'(a_tc), 64'h0);
        rst = 1'b1;
        tick();
        check("prio_rst_q", 64'(a_q), 64'h0);
        rst = 1'b0; a_load = '0; a_en = '0;

        // Modulus 10, counting down from 0.
        m_en = 1'b1; m_up = 1'b0;
        tick();
        check("mod_q9",  64'(m_q),   64'h9);
        check("mod_tc",  64'(m_tc),  64'h1);
        check("mod_ovf", 64'(m_ovf), 64'h1);
        tick();
        check("mod_q8",    64'(m_q),  64'h8);
        check("mod_tc_end", 64'(m_tc), 64'h0);
        m_load = 1'b1; m_lv = 4'd15;
        tick();
        check("mod_clamp", 64'(m_q),  64'h9);
        check("mod_ld_tc", 64'(m_tc), 64'h0);
        m_load = 1'b0; m_en = 1'b0;
        tick();
        check("mod_hold", 64'(m_q), 64'h9);

        // Saturate at 5; ovf_clr with the event leaves ovf set.
        s_en = 1'b1; s_up = 1'b1;
        repeat (5) tick();
        check("sat_q5",    64'(s_q),  64'h5);
        check("sat_tc_pre", 64'(s_tc), 64'h0);
        tick();
        check("sat_hold", 64'(s_q),   64'h5);
        check("sat_tc",   64'(s_tc),  64'h1);
        check("sat_ovf",  64'(s_ovf), 64'h1);
        s_clr = 1'b1;
        tick();
        check("sat_tc2",     64'(s_tc),  64'h1);
        check("sat_set_win", 64'(s_ovf), 64'h1);
        s_en = 1'b0;
        tick();
        check("sat_tc_off", 64'(s_tc),  64'h0);
        check("sat_clr",    64'(s_ovf), 64'h0);
        s_clr = 1'b0;

        // Cascade up: ch1 steps on ch0 wrap; full 12-bit rollover at 4096.
        rst = 1'b1;
        tick();
        rst = 1'b0; c_en = 3'b111; c_up = 3'b111;
        repeat (16) tick();
        check("cas_q16",  64'(c_q),  64'h010);
        check("cas_tc16", 64'(c_tc), 64'h1);
        repeat (240) tick();
        check("cas_q256",   64'(c_q),      64'h100);
        check("cas_tc256",  64'(c_tc),     64'h3);
        check("cas_ovf2",   64'(c_ovf[2]), 64'h0);
        repeat (3840) tick();
        check("cas_q4096",  64'(c_q),  64'h000);
        check("cas_tc4096", 64'(c_tc), 64'h7);

        // Cascade down: a load on ch0 at 0 blocks ch1's decrement.
        c_en = '0; c_load = 3'b011; c_lv = 12'h050;
        tick();
        check("cas_preload", 64'(c_q), 64'h050);
        c_en = 3'b111; c_up = 3'b000; c_load = 3'b001; c_lv = 12'h000;
        tick();
        check("cas_ld_block", 64'(c_q),  64'h050);
        check("cas_ld_tc",    64'(c_tc), 64'h0);
        c_load = '0;
        tick();
        check("cas_dn_q",  64'(c_q),  64'h04F);
        check("cas_dn_tc", 64'(c_tc), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
